// File: rtl/leaf_user_stream_fifo.sv
// ----------------------------------------------------------------------------
// leaf_user_stream_fifo
//
// Elastic first-word-fall-through buffer between an HLS operator output
// stream (ap_vld/ap_ack) and one input port of a leaf interface wrapper.
// The operator's back-pressure is decoupled from the wrapper's acknowledge
// timing. Every output is driven straight from a register.
//
// Ports:
//   clk       in   single clock
//   reset     in   asynchronous active-low reset (0 = in reset)
//   din       in   DATA_BITS   word from the upstream operator
//   din_vld   in   1           upstream word valid
//   din_ack   out  1           buffer accepts the word this cycle (registered)
//   dout      out  DATA_BITS   head word (registered, FWFT)
//   dout_vld  out  1           head word valid
//   dout_ack  in   1           wrapper consumes the head this cycle
//   count     out  DEPTH_BITS+1  words held, head included (0..DEPTH)
// ----------------------------------------------------------------------------
module leaf_user_stream_fifo #(
    parameter int DATA_BITS  = 32,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_BITS-1:0]  din,
    input  logic                  din_vld,
    output logic                  din_ack,
    output logic [DATA_BITS-1:0]  dout,
    output logic                  dout_vld,
    input  logic                  dout_ack,
    output logic [DEPTH_BITS:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   CNT_ONE   = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS:0]   CNT_ZERO  = (DEPTH_BITS+1)'(0);
    localparam logic [DEPTH_BITS:0]   CNT_DEPTH = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE   = DEPTH_BITS'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ZERO  = DEPTH_BITS'(0);

    logic [DATA_BITS-1:0]  r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  r_din_ack;
    logic                  r_dout_vld;
    logic [DATA_BITS-1:0]  r_dout;

    logic                  w_wr;
    logic                  w_rd;
    logic [DEPTH_BITS:0]   w_count_next;
    logic [DEPTH_BITS-1:0] w_rd_ptr_inc;

    assign w_wr         = din_vld & r_din_ack;
    assign w_rd         = r_dout_vld & dout_ack;
    assign w_rd_ptr_inc = r_rd_ptr + PTR_ONE;

    // Next occupancy: a simultaneous read and write leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage array; written only on a write transfer, never reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, registered acknowledge and FWFT head register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= PTR_ZERO;
            r_rd_ptr   <= PTR_ZERO;
            r_count    <= CNT_ZERO;
            r_din_ack  <= 1'b0;
            r_dout_vld <= 1'b0;
            r_dout     <= {DATA_BITS{1'b0}};
        end else begin
            r_count   <= w_count_next;
            r_din_ack <= (w_count_next < CNT_DEPTH);
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_rd) begin
                // Head consumed: the next head is either the word behind it
                // in the array, the word arriving now (count was 1), or none.
                if (w_count_next == CNT_ZERO) begin
                    r_dout_vld <= 1'b0;
                end else if (r_count == CNT_ONE) begin
                    r_dout     <= din;
                    r_dout_vld <= 1'b1;
                end else begin
                    r_dout     <= r_mem[w_rd_ptr_inc];
                    r_dout_vld <= 1'b1;
                end
            end else if (w_wr && (r_count == CNT_ZERO)) begin
                // Write into an empty buffer falls straight through to the head.
                r_dout     <= din;
                r_dout_vld <= 1'b1;
            end
        end
    end

    assign din_ack  = r_din_ack;
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign count    = r_count;

endmodule

// File: tb/tb_leaf_user_stream_fifo.sv
// ----------------------------------------------------------------------------
// Directed bench for leaf_user_stream_fifo: reset, single word, fill to full,
// release from full, streaming, randomised wrap-around against a queue model,
// and asynchronous reset mid-burst.
// ----------------------------------------------------------------------------
module tb_leaf_user_stream_fifo;

    localparam int DATA_BITS  = 32;
    localparam int DEPTH_BITS = 4;
    localparam int DEPTH      = 16;

    logic                 clk;
    logic                 reset;
    logic [DATA_BITS-1:0] din;
    logic                 din_vld;
    logic                 din_ack;
    logic [DATA_BITS-1:0] dout;
    logic                 dout_vld;
    logic                 dout_ack;
    logic [DEPTH_BITS:0]  count;

    int vectors;
    int miscompares;

    leaf_user_stream_fifo #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .din_vld  (din_vld),
        .din_ack  (din_ack),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_ack (dout_ack),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [DATA_BITS-1:0] q[$];
    int  m_count;
    bit  m_ack;
    int  writes;
    int  cycles;
    bit  v;
    bit  a;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        din         = 32'h0;
        din_vld     = 1'b0;
        dout_ack    = 1'b0;

        // ---- 1: reset, release, single word ----
        repeat (3) tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_vld",   64'(dout_vld), 64'd0);
        chk("rst_ack",   64'(din_ack), 64'd0);
        chk("rst_dout",  64'(dout), 64'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_ack",   64'(din_ack), 64'd1);
        chk("post_rst_count", 64'(count), 64'd0);
        chk("post_rst_vld",   64'(dout_vld), 64'd0);
        din = 32'h0000_00A5; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        chk("a5_dout",  64'(dout), 64'hA5);
        chk("a5_vld",   64'(dout_vld), 64'd1);
        chk("a5_count", 64'(count), 64'd1);
        dout_ack = 1'b1;
        tick();
        dout_ack = 1'b0;
        chk("a5_drain_vld",   64'(dout_vld), 64'd0);
        chk("a5_drain_count", 64'(count), 64'd0);

        // ---- 2: fill to full, 17th word ignored ----
        for (int i = 1; i <= 16; i++) begin
            din = 32'(i); din_vld = 1'b1;
            tick();
        end
        chk("full_count", 64'(count), 64'd16);
        chk("full_ack",   64'(din_ack), 64'd0);
        chk("full_head",  64'(dout), 64'h1);
        din = 32'h0000_DEAD; din_vld = 1'b1;
        repeat (2) tick();
        chk("full_hold_count", 64'(count), 64'd16);
        chk("full_hold_ack",   64'(din_ack), 64'd0);
        chk("full_hold_head",  64'(dout), 64'h1);

        // ---- 3: one read from full, then DEAD accepted last ----
        dout_ack = 1'b1;
        tick();
        dout_ack = 1'b0;
        chk("rel_head",  64'(dout), 64'h2);
        chk("rel_count", 64'(count), 64'd15);
        chk("rel_ack",   64'(din_ack), 64'd1);
        tick();
        din_vld = 1'b0;
        chk("dead_count", 64'(count), 64'd16);
        chk("dead_ack",   64'(din_ack), 64'd0);
        dout_ack = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            chk("drain_vld", 64'(dout_vld), 64'd1);
            chk("drain_data", 64'(dout), (i == 17) ? 64'hDEAD : 64'(i));
            chk("drain_count", 64'(count), 64'(18 - i));
            tick();
        end
        dout_ack = 1'b0;
        chk("drain_empty_vld",   64'(dout_vld), 64'd0);
        chk("drain_empty_count", 64'(count), 64'd0);
        // dout_ack while empty must not underflow
        dout_ack = 1'b1;
        tick();
        dout_ack = 1'b0;
        chk("underflow_count", 64'(count), 64'd0);

        // ---- 4: streaming, 1 word/cycle ----
        din_vld = 1'b1; dout_ack = 1'b1;
        for (int k = 0; k < 100; k++) begin
            din = 32'(k);
            tick();
            chk("stream_data",  64'(dout), 64'(k));
            chk("stream_vld",   64'(dout_vld), 64'd1);
            chk("stream_count", 64'(count), 64'd1);
        end
        din_vld = 1'b0;
        tick();
        dout_ack = 1'b0;
        chk("stream_end_count", 64'(count), 64'd0);
        chk("stream_end_vld",   64'(dout_vld), 64'd0);

        // ---- 5: random wrap-around against a queue model ----
        q.delete();
        m_count = 0;
        m_ack   = 1'b1;
        writes  = 0;
        cycles  = 0;
        while ((writes < 1000) && (cycles < 8000)) begin
            chk("rnd_ack",   64'(din_ack), 64'(m_ack));
            chk("rnd_count", 64'(count), 64'(m_count));
            chk("rnd_vld",   64'(dout_vld), 64'(m_count > 0));
            if (m_count > 0) chk("rnd_data", 64'(dout), 64'(q[0]));
            v = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            din      = $urandom();
            din_vld  = v;
            dout_ack = a;
            if (a && (m_count > 0)) void'(q.pop_front());
            if (v && m_ack) begin
                q.push_back(din);
                writes++;
            end
            m_count = q.size();
            m_ack   = (m_count < DEPTH);
            cycles++;
            tick();
        end
        chk("rnd_budget", 64'(writes >= 1000), 64'd1);
        din_vld  = 1'b0;
        dout_ack = 1'b1;
        cycles   = 0;
        while ((q.size() > 0) && (cycles < 40)) begin
            chk("rnd_drain_data", 64'(dout), 64'(q[0]));
            void'(q.pop_front());
            cycles++;
            tick();
        end
        dout_ack = 1'b0;
        chk("rnd_drain_count", 64'(count), 64'd0);

        // ---- 6: asynchronous reset mid-burst ----
        for (int i = 0; i < 7; i++) begin
            din = 32'(32'h100 + i); din_vld = 1'b1;
            tick();
        end
        chk("burst_count", 64'(count), 64'd7);
        #2;
        reset = 1'b0;
        #1;
        chk("async_vld",   64'(dout_vld), 64'd0);
        chk("async_ack",   64'(din_ack), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_dout",  64'(dout), 64'd0);
        din_vld = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rerst_ack", 64'(din_ack), 64'd1);
        din = 32'h55; din_vld = 1'b1;
        tick();
        din_vld  = 1'b0;
        chk("rerst_dout",  64'(dout), 64'h55);
        chk("rerst_vld",   64'(dout_vld), 64'd1);
        chk("rerst_count", 64'(count), 64'd1);
        dout_ack = 1'b1;
        tick();
        dout_ack = 1'b0;
        chk("rerst_drain", 64'(count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
